// File: rtl/baud_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// baud_tick_gen : fractional-divisor oversample / bit / mid-bit tick generator
// Revision      : 1.0
// ============================================================================
module baud_tick_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 8,
  parameter int OVS_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic [OVS_W-1:0]  cfg_ovs,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam logic [DIV_W-1:0] c_DIV_MIN = DIV_W'(2);
  localparam logic [OVS_W-1:0] c_OVS_MIN = OVS_W'(1);
  localparam logic [OVS_W-1:0] c_OVS_ONE = OVS_W'(1);
  localparam logic [DIV_W:0]   c_CNT_ONE = (DIV_W+1)'(1);

  logic [DIV_W-1:0]  r_div;
  logic [FRAC_W-1:0] r_frac;
  logic [OVS_W-1:0]  r_ovs;
  logic [DIV_W:0]    r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic [OVS_W-1:0]  r_ovs_cnt;

  logic [DIV_W-1:0]  w_div_ld;
  logic [OVS_W-1:0]  w_ovs_ld;
  logic [FRAC_W:0]   w_frac_sum;
  logic [DIV_W:0]    w_period;
  logic              w_tick;
  logic              w_ovs_last;
  logic [OVS_W-1:0]  w_ovs_next;
  logic [OVS_W-1:0]  w_mid_pt;

  assign w_div_ld = (cfg_div_int < c_DIV_MIN) ? c_DIV_MIN : cfg_div_int;
  assign w_ovs_ld = (cfg_ovs == '0) ? c_OVS_MIN : cfg_ovs;

  // The carry of the running fraction stretches the current interval by one cycle.
  assign w_frac_sum = {1'b0, r_acc} + {1'b0, r_frac};
  assign w_period   = {1'b0, r_div} + {{DIV_W{1'b0}}, w_frac_sum[FRAC_W]};
  assign w_tick     = (r_cnt >= w_period);

  assign w_ovs_last = (r_ovs_cnt == (r_ovs - c_OVS_ONE));
  assign w_ovs_next = w_ovs_last ? '0 : (r_ovs_cnt + c_OVS_ONE);
  assign w_mid_pt   = r_ovs >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      os_tick   <= 1'b0;
      bit_tick  <= 1'b0;
      mid_tick  <= 1'b0;
      r_cnt     <= c_CNT_ONE;
      r_acc     <= '0;
      r_ovs_cnt <= '0;
      r_div     <= w_div_ld;
      r_frac    <= cfg_div_frac;
      r_ovs     <= w_ovs_ld;
    end else if (en) begin
      if (restart) begin
        os_tick   <= 1'b0;
        bit_tick  <= 1'b0;
        mid_tick  <= 1'b0;
        r_cnt     <= c_CNT_ONE;
        r_acc     <= '0;
        r_ovs_cnt <= '0;
        r_div     <= w_div_ld;
        r_frac    <= cfg_div_frac;
        r_ovs     <= w_ovs_ld;
      end else begin
        os_tick  <= w_tick;
        bit_tick <= w_tick && w_ovs_last;
        mid_tick <= w_tick && (w_ovs_next == w_mid_pt);
        if (w_tick) begin
          r_cnt     <= c_CNT_ONE;
          r_acc     <= w_frac_sum[FRAC_W-1:0];
          r_ovs_cnt <= w_ovs_next;
          // New settings only take hold at a bit boundary.
          if (w_ovs_last) begin
            r_div  <= w_div_ld;
            r_frac <= cfg_div_frac;
            r_ovs  <= w_ovs_ld;
          end
        end else begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_baud_tick_gen : directed vector bench for baud_tick_gen
// Revision         : 1.0
// ============================================================================
module tb_baud_tick_gen;

  // Narrow divisor so the full-scale divisor+fraction corner stays short.
  localparam int DIV_W  = 8;
  localparam int FRAC_W = 8;
  localparam int OVS_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic              restart = 1'b0;
  logic [DIV_W-1:0]  cfg_div_int = '0;
  logic [FRAC_W-1:0] cfg_div_frac = '0;
  logic [OVS_W-1:0]  cfg_ovs = '0;
  logic              os_tick, bit_tick, mid_tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS_W(OVS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .cfg_ovs(cfg_ovs),
    .os_tick(os_tick), .bit_tick(bit_tick), .mid_tick(mid_tick)
  );

  typedef struct {
    int div; int frac; int ovs; int n;
    int total; int bits; int mids; int pmin; int pmax;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int div, input int frac, input int ovs);
    cfg_div_int  = DIV_W'(div);
    cfg_div_frac = FRAC_W'(frac);
    cfg_ovs      = OVS_W'(ovs);
    en = 1'b1; restart = 1'b0; rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Cycles until the selected strobe (0 os, 1 mid, 2 bit) is seen; -1 on timeout.
  task automatic wait_tick(input int sel, input int budget, output int cyc);
    logic s;
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      s = (sel == 0) ? os_tick : (sel == 1) ? mid_tick : bit_tick;
      if (s) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_vec(input int k);
    int cyc, ticks, last, nb, nm, pmin, pmax, p;
    do_reset(vecs[k].div, vecs[k].frac, vecs[k].ovs);
    cyc = 0; ticks = 0; last = 0; nb = 0; nm = 0; pmin = 1 << 30; pmax = 0;
    while (ticks < vecs[k].n && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      if (bit_tick) nb++;
      if (mid_tick) nm++;
      if (os_tick) begin
        ticks++;
        p = cyc - last;
        last = cyc;
        if (p < pmin) pmin = p;
        if (p > pmax) pmax = p;
      end
    end
    check($sformatf("vec%0d total_cycles", k), cyc, vecs[k].total);
    check($sformatf("vec%0d bit_ticks", k), nb, vecs[k].bits);
    check($sformatf("vec%0d mid_ticks", k), nm, vecs[k].mids);
    check($sformatf("vec%0d min_period", k), pmin, vecs[k].pmin);
    check($sformatf("vec%0d max_period", k), pmax, vecs[k].pmax);
  endtask

  initial begin
    int c, cnt;
    //          div  frac ovs  n    total  bits mids pmin pmax
    vecs[0] = '{35,  0,   16,  32,  1120,  2,   2,   35,  35};
    vecs[1] = '{35,  207, 16,  256, 9167,  16,  16,  35,  36};
    vecs[2] = '{0,   0,   4,   8,   16,    2,   2,   2,   2};
    vecs[3] = '{1,   128, 0,   6,   15,    6,   6,   2,   3};
    vecs[4] = '{255, 255, 2,   3,   767,   1,   2,   255, 256};

    // Reset state
    cfg_div_int = 8'd35; cfg_ovs = 5'd16;
    step(3);
    check("reset outputs", int'({os_tick, bit_tick, mid_tick}), 0);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Restart on an edge where a tick would fire
    do_reset(35, 0, 16);
    step(104);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart suppresses tick", int'({os_tick, bit_tick, mid_tick}), 0);
    wait_tick(0, 200, c);  check("restart first os", c, 35);
    wait_tick(1, 600, c);  check("restart mid", c, 245);
    wait_tick(2, 600, c);  check("restart bit", c, 280);

    // Divisor change halfway through a bit
    do_reset(35, 0, 16);
    step(280);
    cfg_div_int = 8'd70;
    wait_tick(2, 1000, c); check("cfg change old bit", c, 280);
    wait_tick(0, 200, c);  check("cfg change new os", c, 70);
    wait_tick(2, 2000, c); check("cfg change new bit", c, 1050);

    // Enable low holds state and ignores restart
    do_reset(35, 0, 16);
    step(20);
    en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      restart = (i == 50);
      step(1);
      if (os_tick || bit_tick || mid_tick) cnt++;
    end
    restart = 1'b0;
    check("en low no ticks", cnt, 0);
    en = 1'b1;
    wait_tick(0, 200, c);  check("en resume os", c, 15);

    // Reset on an edge where a tick would fire
    do_reset(35, 0, 16);
    step(69);
    rst = 1'b1;
    step(1);
    check("rst mid-period outputs", int'({os_tick, bit_tick, mid_tick}), 0);
    rst = 1'b0;
    wait_tick(0, 200, c);  check("post-rst first os", c, 35);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
